// File: rtl/spi_pkg.sv
// Shared encodings for the parametrised SPI slave: FSM states and command codes.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADDR = 3'd3,
        READ_DATA = 3'd4
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// MISO serializer: loads a readback word, shifts it out MSB first, then parks MISO low.
module spi_tx_serializer #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] data,
    output logic              MISO,
    output logic              done
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] shift_q, shift_d;
    logic              active_q, active_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // done is asserted on the edge that retires the last bit (LSB)
    always_comb begin
        shift_d  = shift_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        done     = 1'b0;
        if (clear) begin
            shift_d  = '0;
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (active_q) begin
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                done     = 1'b1;
                shift_d  = '0;
                active_d = 1'b0;
                cnt_d    = '0;
            end else begin
                shift_d = {shift_q[DATA_W-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end else if (load) begin
            shift_d  = data;
            active_d = 1'b1;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= '0;
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            shift_q  <= shift_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

    assign MISO = shift_q[DATA_W-1];

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: frame deserialiser, read-address/read-data tracking,
// MISO readback and frame-error reporting for aborted transfers.
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CMD_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     SS_n,
    input  logic                     MOSI,
    output logic                     MISO,
    output logic [CMD_W+DATA_W-1:0]  rx_data,
    output logic                     rx_valid,
    input  logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_valid,
    output logic                     frame_err,
    output logic                     busy
);

    localparam int unsigned FRAME_W = CMD_W + DATA_W;
    localparam int unsigned SHIFT_W = FRAME_W - 1;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;
    logic                 rd_seen_q, rd_seen_d;
    logic                 tx_started_q, tx_started_d;
    logic                 tx_load_c;
    logic                 tx_done_c;

    // Next-state and output logic; SS_n rising outside IDLE takes priority
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        rd_seen_d    = rd_seen_q;
        tx_started_d = tx_started_q;
        tx_load_c    = 1'b0;

        if (state_q != IDLE && SS_n) begin
            state_d      = IDLE;
            bit_cnt_d    = '0;
            tx_started_d = 1'b0;
            if (bit_cnt_q != '0 && bit_cnt_q < CNT_W'(FRAME_W)) begin
                frame_err_d = 1'b1;
            end
            if (state_q == READ_DATA) begin
                rd_seen_d = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d = '0;
                    if (!SS_n) begin
                        state_d = CHK_CMD;
                    end
                end
                CHK_CMD: begin
                    shift_d   = {shift_q[SHIFT_W-2:0], MOSI};
                    bit_cnt_d = CNT_W'(1);
                    state_d   = MOSI ? (rd_seen_q ? READ_DATA : READ_ADDR) : WRITE;
                end
                default: begin
                    if (bit_cnt_q < CNT_W'(FRAME_W)) begin
                        shift_d   = {shift_q[SHIFT_W-2:0], MOSI};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
                            rx_data_d  = {shift_q, MOSI};
                            rx_valid_d = 1'b1;
                            if (state_q == READ_ADDR) begin
                                rd_seen_d = 1'b1;
                            end
                        end
                    end else if (state_q == READ_DATA) begin
                        // A single readback per READ_DATA frame
                        if (!tx_started_q && tx_valid) begin
                            tx_load_c    = 1'b1;
                            tx_started_d = 1'b1;
                        end
                        if (tx_done_c) begin
                            rd_seen_d = 1'b0;
                        end
                    end
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            rd_seen_q    <= 1'b0;
            tx_started_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
            rd_seen_q    <= rd_seen_d;
            tx_started_q <= tx_started_d;
        end
    end

    spi_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .load  (tx_load_c),
        .clear (SS_n),
        .data  (tx_data),
        .MISO  (MISO),
        .done  (tx_done_c)
    );

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: vector table of frames/readbacks plus
// hand-written abort, reset-mid-readback, abandoned-readback and overlong-frame sequences.
module tb_spi_slave_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       frame_err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    spi_slave_param #(
        .DATA_W (8),
        .CMD_W  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] frame;
        logic [7:0] tx;
        logic [9:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Select, one idle edge, then n bits MSB first; SS_n left low
    task automatic send(input logic [31:0] bits, input int n, output int vcnt,
                        output logic last_valid, output logic miso_seen);
        vcnt      = 0;
        miso_seen = 1'b0;
        SS_n      = 1'b0;
        MOSI      = 1'b0;
        tick();
        miso_seen |= MISO;
        for (int k = n - 1; k >= 0; k--) begin
            MOSI = bits[k];
            tick();
            if (rx_valid) vcnt++;
            miso_seen |= MISO;
        end
        last_valid = rx_valid;
        MOSI = 1'b0;
    endtask

    // tx_valid held high throughout, so reloads after completion would show on tail
    task automatic readback(input logic [7:0] b, output logic [7:0] got,
                            output logic tail, output logic rv_first);
        tx_data  = b;
        tx_valid = 1'b1;
        rv_first = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            tick();
            if (i == 7) rv_first = rx_valid;
            got[i] = MISO;
        end
        tick();
        tail = MISO;
        tick();
        tail |= MISO;
        tx_valid = 1'b0;
    endtask

    initial begin
        int         vc;
        logic       lv;
        logic       ms;
        logic [7:0] got;
        logic       tail;
        logic       rv1;

        vecs[0] = '{10'b00_1010_0101, 8'hA5, 10'h0A5, 8'h00};
        vecs[1] = '{10'b01_1111_0000, 8'hFF, 10'h1F0, 8'h00};
        vecs[2] = '{10'b11_0000_0000, 8'h5A, 10'h300, 8'h00};
        vecs[3] = '{10'b11_0101_0101, 8'hC3, 10'h355, 8'hC3};
        vecs[4] = '{10'b10_0000_0011, 8'h81, 10'h203, 8'h00};
        vecs[5] = '{10'b00_0000_0001, 8'h77, 10'h001, 8'h00};
        vecs[6] = '{10'b10_1100_1100, 8'h96, 10'h2CC, 8'h96};
        vecs[7] = '{10'b11_1111_1111, 8'h3C, 10'h3FF, 8'h00};

        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;
        tick();
        tick();
        check("reset MISO", 32'(MISO), 32'd0);
        check("reset rx_data", 32'(rx_data), 32'd0);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            send(32'(vecs[i].frame), 10, vc, lv, ms);
            check($sformatf("v%0d rx_valid at end", i), 32'(lv), 32'd1);
            check($sformatf("v%0d rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx));
            check($sformatf("v%0d rx_valid count", i), 32'(vc), 32'd1);
            check($sformatf("v%0d MISO during rx", i), 32'(ms), 32'd0);
            readback(vecs[i].tx, got, tail, rv1);
            check($sformatf("v%0d rx_valid one cycle", i), 32'(rv1), 32'd0);
            check($sformatf("v%0d readback", i), 32'(got), 32'(vecs[i].exp_miso));
            check($sformatf("v%0d MISO after", i), 32'(tail), 32'd0);
            check($sformatf("v%0d busy held", i), 32'(busy), 32'd1);
            SS_n = 1'b1;
            tick();
            check($sformatf("v%0d frame_err", i), 32'(frame_err), 32'd0);
            check($sformatf("v%0d busy drop", i), 32'(busy), 32'd0);
        end

        // Abort after 4 bits of a write frame
        send(32'b0110, 4, vc, lv, ms);
        SS_n = 1'b1;
        tick();
        check("abort frame_err", 32'(frame_err), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort rx_valid", 32'(rx_valid), 32'd0);
        check("abort rx_valid count", 32'(vc), 32'd0);
        check("abort rx_data kept", 32'(rx_data), 32'h3FF);
        tick();
        check("abort frame_err pulse", 32'(frame_err), 32'd0);

        // Reset during readback bit 3 of 8'hFF
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(32'(10'b10_0000_0000), 10, vc, lv, ms);
        SS_n = 1'b1;
        tick();
        send(32'(10'b11_0000_1111), 10, vc, lv, ms);
        check("rstrb rx_data", 32'(rx_data), 32'h30F);
        tx_data = 8'hFF; tx_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("rstrb MISO bit3", 32'(MISO), 32'd1);
        rst = 1'b1;
        tick();
        check("rstrb MISO", 32'(MISO), 32'd0);
        check("rstrb busy", 32'(busy), 32'd0);
        check("rstrb rx_valid", 32'(rx_valid), 32'd0);
        check("rstrb frame_err", 32'(frame_err), 32'd0);
        check("rstrb rx_data", 32'(rx_data), 32'd0);
        rst = 1'b0; SS_n = 1'b1; tx_valid = 1'b0;
        tick();
        check("rstrb post frame_err", 32'(frame_err), 32'd0);
        send(32'(10'b11_1010_1010), 10, vc, lv, ms);
        check("rstrb routed rx_data", 32'(rx_data), 32'h3AA);
        readback(8'h3C, got, tail, rv1);
        check("rstrb routed to addr", 32'(got), 32'd0);
        SS_n = 1'b1;
        tick();

        // Readback abandoned after 3 bits; next read must be an address read
        send(32'(10'b11_0000_0001), 10, vc, lv, ms);
        tx_data = 8'hA5; tx_valid = 1'b1;
        tick();
        check("abandon bit7", 32'(MISO), 32'd1);
        tick();
        tick();
        SS_n = 1'b1; tx_valid = 1'b0;
        tick();
        check("abandon MISO", 32'(MISO), 32'd0);
        check("abandon frame_err", 32'(frame_err), 32'd0);
        check("abandon busy", 32'(busy), 32'd0);
        send(32'(10'b11_0000_0010), 10, vc, lv, ms);
        readback(8'h5A, got, tail, rv1);
        check("abandon rd_seen cleared", 32'(got), 32'd0);
        SS_n = 1'b1;
        tick();

        // Overlong write frame: 14 bits, one rx_valid with the first 10
        send({18'd0, 10'b00_1100_1101, 4'b1111}, 14, vc, lv, ms);
        check("overlong rx_valid count", 32'(vc), 32'd1);
        check("overlong rx_data", 32'(rx_data), 32'h0CD);
        SS_n = 1'b1;
        tick();
        check("overlong frame_err", 32'(frame_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
- Parametrised next-generation SPI slave; frame and data widths are generics.
- Deserialises MOSI frames (command + payload) and presents each frame on rx_data with a one-cycle rx_valid.
- Serialises tx_data onto MISO for read-data transactions.
- Sits between the SPI pins and the RAM/register back-end. Adds two things earlier slaves lack: read-address/read-data tracking across frames, and a frame-error report for aborted transfers.

Parameters:
- DATA_W, 8, payload and readback width in bits.
- CMD_W, 2, command field width. Bit [CMD_W-1] is the R/W bit (1 = read). Bit [0] is the addr/data select.
- FRAME_W, CMD_W+DATA_W, bits per inbound frame. Derived; not overridable.

Ports:
- clk  in  1  SPI-domain clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- SS_n  in  1  slave select, active low.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first; 0 when not transmitting.
- rx_data  out  FRAME_W  last complete inbound frame, {cmd, payload}.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- tx_data  in  DATA_W  readback data from back-end.
- tx_valid  in  1  tx_data valid; sampled only in READ_DATA after the frame completes.
- frame_err  out  1  one-cycle pulse: SS_n rose mid-frame.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: MISO=0, rx_data=0, rx_valid=0, frame_err=0, busy=0, state=IDLE, bit_cnt=0, rd_addr_seen=0, tx_shift=0, tx_active=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADDR, READ_DATA.
- IDLE:
  - SS_n=0 at edge 0 -> CHK_CMD. No bit is captured at edge 0.
- CHK_CMD (edge 1): MOSI is captured as frame bit FRAME_W-1, bit_cnt=1.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADDR.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADDR / READ_DATA, receive phase:
  - One MOSI bit per edge, shifted in MSB first, until bit_cnt=FRAME_W (edge FRAME_W).
  - At that edge the shift content, including the bit sampled at that edge, loads rx_data, and rx_valid=1 for exactly the next cycle.
- After a frame completes in WRITE or READ_ADDR:
  - Further MOSI bits are ignored. No second rx_valid until SS_n returns high and falls again.
  - READ_ADDR completion sets rd_addr_seen=1.
- READ_DATA after frame completion:
  - Wait for tx_valid=1 (indefinitely while SS_n=0).
  - On the edge sampling tx_valid=1: load tx_shift=tx_data, set tx_active. MISO shows tx_data[DATA_W-1] after that edge.
  - Each subsequent edge presents the next lower bit.
  - After DATA_W bits: MISO=0, tx_active=0, rd_addr_seen=0.
  - tx_valid is ignored while tx_active, and after the transfer is done.
- SS_n=1 in any non-IDLE state -> IDLE at that edge; bit_cnt is cleared.
  - If 1 <= bit_cnt < FRAME_W, frame_err pulses one cycle, rx_data is unchanged, no rx_valid.
  - A partial READ_DATA readback is abandoned (MISO=0) and rd_addr_seen is still cleared. An early SS_n rise in READ_ADDR leaves rd_addr_seen unchanged.
- rst=1 overrides everything, including mid-frame: state=IDLE and all registers go to their reset values, no pulses.
- busy is registered, equal to (state != IDLE).
- bit_cnt width is $clog2(FRAME_W+1) and saturates at FRAME_W. No wrap-around.

Decomposition:
- Shared package spi_pkg holds:
  - the state encoding: IDLE=3'd0, CHK_CMD=3'd1, WRITE=3'd2, READ_ADDR=3'd3, READ_DATA=3'd4;
  - command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
- One sub-module, spi_tx_serializer (DATA_W): the load/shift/count logic for MISO. Inputs load, data, clear. Outputs MISO, done.

Test Plan:
- Write address: rst, SS_n=0, send 10'b00_1010_0101 -> after edge 10, rx_data=10'h0A5 and rx_valid=1 for 1 cycle. MISO stays 0. SS_n=1 -> IDLE, no frame_err.
- Read address then read data:
  - Send 10'b10_0000_0011, SS_n=1.
  - Then send 10'b11_xxxx_xxxx -> FSM enters READ_DATA (not READ_ADDR). rx_valid pulses.
  - Drive tx_data=8'hC3, tx_valid=1 -> MISO yields 1,1,0,0,0,0,1,1 on the following 8 edges, then 0. rd_addr_seen clears.
- Abort: SS_n=0, send 4 bits, SS_n=1 -> frame_err=1 for one cycle, rx_valid never asserts, rx_data keeps its prior value, busy drops.
- Read-data without prior read-address: first frame 10'b11_0000_0000 after rst -> routed to READ_ADDR. rx_valid pulses with rx_data=10'h300.
- Reset mid-readback: during MISO bit 3 of 8'hFF, assert rst for 1 cycle -> MISO=0, state IDLE, rd_addr_seen=0, no rx_valid/frame_err pulses.
- Overlong frame: hold SS_n=0 for 14 bits in WRITE -> exactly one rx_valid, carrying the first 10 bits.
